pe_array_acc: RTL and testbench
===============================

// Module: pe_array_acc
// PURPOSE
//  Second-generation PE array: PE_CORE_NUM output-channel lanes, each a K-tap signed dot product
//  accumulated over a multi-beat frame (input channels x kernel rows). Frame init from per-lane bias
//  or residual; rounding shift, saturation and optional ReLU at the end. Valid/ready on both sides.
//  Sits between the feature/weight buffers and the output writeback in the conv datapath.
// PARAMETERS
//  FEATURE_WIDTH     16  signed feature width
//  WEIGHT_WIDTH      16  signed weight width
//  PE_NUM_PRE_CORE   3   taps K per lane (features per beat)
//  PE_CORE_NUM       16  lanes (output channels)
//  ACC_WIDTH         48  accumulator width; >= FEATURE_WIDTH+WEIGHT_WIDTH+clog2(K)
//  OUT_WIDTH         32  output width per lane (MAC_OUTPUT_WIDTH)
// PORTS
//  DSP_clk       in   1                    clock
//  rst           in   1                    synchronous, active-high reset
//  in_valid      in   1                    beat valid
//  in_ready      out  1                    beat accepted when in_valid&&in_ready
//  in_first      in   1                    first beat of frame: load init
//  in_last       in   1                    last beat of frame: emit result
//  feature_in    in   FEATURE_WIDTH*K      K taps shared by all lanes, tap0 in LSBs
//  weight        in   WEIGHT_WIDTH*K*PE_CORE_NUM  lane-major, tap-minor
//  bias          in   ACC_WIDTH*PE_CORE_NUM      per-lane bias (sampled on first beat)
//  adder_feature in   OUT_WIDTH*PE_CORE_NUM      per-lane residual (sign-extended, first beat)
//  init_sel      in   1                    0=bias, 1=adder_feature (first beat)
//  cfg_k1        in   1                    1x1 mode: only tap0 used, other taps forced 0 (per beat)
//  cfg_shift     in   5                    arithmetic right shift at output (sampled on first beat)
//  cfg_relu      in   1                    clamp negatives to 0 (sampled on first beat)
//  out_valid     out  1                    result valid
//  out_ready     in   1                    consumer accepts
//  feature_out   out  OUT_WIDTH*PE_CORE_NUM lane i at [i*OUT_WIDTH +: OUT_WIDTH]
//  err_proto     out  1                    sticky protocol error
// BEHAVIOUR
//  - Reset: out_valid=0, feature_out=0, err_proto=0, all pipeline valids 0, accumulators 0, frame closed.
//  - Global stall en = !(out_valid && !out_ready); in_ready = en; all pipeline regs hold when !en.
//  - Stage1 (edge after acceptance): K products per lane registered, plus first/last/init tags.
//  - Stage2 (next edge): dot=sum(products); first: acc=init+dot, else acc=acc+dot; acc wraps mod 2^ACC_WIDTH.
//  - On last at stage2: result -> feature_out, out_valid=1, frame closes. Latency accept->out_valid = 2 edges.
//  - out_valid stays high, feature_out stable, until out_ready; next result may load the same edge it drains.
//  - Post-process: if shift>0 add 1<<(shift-1), then >>> shift; saturate to [-2^(OUT-1), 2^(OUT-1)-1];
//    then ReLU if cfg_relu.
//  - FSM: CLOSED (no frame) -> OPEN on accepted first&&!last; OPEN -> CLOSED on accepted last.
//    first&&last in one beat = single-beat frame.
//  - Errors (set err_proto, sticky): first while OPEN -> old partial sum discarded, restart;
//    non-first beat while CLOSED -> treated as first (init loaded).
//  - in_valid low: bubble, acc unchanged. Config is frame-registered except cfg_k1 (per beat).
//  - rst mid-frame: partial sum, pending output and error flag discarded; next beat requires in_first.
// STRUCTURE
//  - Widths FEATURE_WIDTH, WEIGHT_WIDTH, PE_NUM_PRE_CORE, PE_CORE_NUM, MAC_OUTPUT_WIDTH come from the
//    shared parameters.v; add ACC_WIDTH there. No local macros.
//  - Sub-module pe_lane: K multipliers, adder tree, accumulator, round/sat/ReLU; generated PE_CORE_NUM times.
//  - Top holds FSM, stall, tag pipeline, err_proto; weight/bias slicing in generate loops.
// TESTING
//  1 Single-beat frame, K=3: features {1,2,3}, lane0 w {4,5,6}, bias 10, shift 0
//    -> lane0 out 42, out_valid 2 cycles after accept.
//  2 Frame of 4 beats, all features 1, weights 2, bias 0 -> each lane 24; no intermediate out_valid.
//  3 init_sel=1, adder_feature lane5=-100, dot 30, cfg_relu=1 -> lane5 out 0; cfg_relu=0 -> -70.
//  4 cfg_shift=4, acc 0x18 -> 2 (round up); acc 0x17 -> 1; acc 2^40 -> 0x7FFFFFFF saturated.
//  5 out_ready low 5 cycles with frames streaming -> in_ready low, feature_out stable, no result lost;
//    back-to-back single-beat frames at full rate give one result per cycle.
//  6 first while OPEN -> err_proto=1, result = new frame only; rst mid-frame -> out_valid 0, err 0.
//    cfg_k1=1 with taps {7,9,9} w {3,9,9} -> 21.

Source files
------------

// File: rtl/pe_array_acc_pkg.sv
// Shared widths and types for the second-generation PE array.
//  - Datapath widths used by pe_array_acc and pe_lane (single source of truth).
//  - frame_state_e : frame tracking FSM states.
//  - frame_cfg_t   : per-frame output configuration (rounding shift, ReLU).
//  - beat_tag_t    : control tags travelling with a beat through stage 1.
package pe_array_acc_pkg;

  localparam int FEATURE_WIDTH    = 16;  // signed feature width
  localparam int WEIGHT_WIDTH     = 16;  // signed weight width
  localparam int PE_NUM_PRE_CORE  = 3;   // taps K per lane
  localparam int PE_CORE_NUM      = 16;  // lanes (output channels)
  localparam int ACC_WIDTH        = 48;  // >= FEATURE_WIDTH+WEIGHT_WIDTH+clog2(K)
  localparam int MAC_OUTPUT_WIDTH = 32;  // output width per lane
  localparam int SHIFT_WIDTH      = 5;   // rounding shift amount width

  typedef enum logic {
    ST_CLOSED = 1'b0,  // no frame in progress
    ST_OPEN   = 1'b1   // frame accumulating
  } frame_state_e;

  typedef struct packed {
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   relu;
  } frame_cfg_t;

  typedef struct packed {
    logic       valid;
    logic       first;  // load init value instead of accumulating
    logic       last;   // emit result after this beat
    frame_cfg_t cfg;    // config of the frame this beat belongs to
  } beat_tag_t;

endpackage

// File: rtl/pe_lane.sv
// One output-channel lane of the PE array.
//  Stage 1: K signed products registered (taps 1..K-1 zeroed in 1x1 mode),
//           init value captured on the frame's first beat.
//  Stage 2: products summed, accumulator loaded (first) or advanced, and on
//           the last beat the rounded/saturated/ReLU result is registered.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  en            global pipeline enable (low = stall, all state holds)
//  in_accept     beat accepted this edge
//  in_first      accepted beat starts a frame (protocol-corrected by top)
//  cfg_k1        1x1 mode for this beat
//  feature_in    K taps, tap0 in LSBs
//  weight        this lane's K weights, tap0 in LSBs
//  init_value    bias or sign-extended residual, used on first beat
//  s1_tag        tags of the beat currently in stage 1
//  feature_out   registered lane result
module pe_lane
  import pe_array_acc_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic                                     in_accept,
  input  logic                                     in_first,
  input  logic                                     cfg_k1,
  input  logic [FEATURE_WIDTH*PE_NUM_PRE_CORE-1:0] feature_in,
  input  logic [WEIGHT_WIDTH*PE_NUM_PRE_CORE-1:0]  weight,
  input  logic [ACC_WIDTH-1:0]                     init_value,
  input  beat_tag_t                                s1_tag,
  output logic [MAC_OUTPUT_WIDTH-1:0]              feature_out
);

  localparam int K  = PE_NUM_PRE_CORE;
  localparam int PW = FEATURE_WIDTH + WEIGHT_WIDTH;
  localparam int OW = MAC_OUTPUT_WIDTH;

  logic signed [FEATURE_WIDTH-1:0] tap_f [K];
  logic signed [WEIGHT_WIDTH-1:0]  tap_w [K];
  logic signed [PW-1:0]            prod_q [K];
  logic        [ACC_WIDTH-1:0]     init_q;
  logic        [ACC_WIDTH-1:0]     dot;
  logic        [ACC_WIDTH-1:0]     acc_d;
  logic        [ACC_WIDTH-1:0]     acc_q;

  // Round half up by adding 1<<(shift-1), arithmetic shift, saturate to the
  // output range, then optional ReLU. One extra bit keeps the rounding add
  // from overflowing at the top of the accumulator range.
  function automatic logic [OW-1:0] post_process(
    input logic [ACC_WIDTH-1:0]   acc,
    input logic [SHIFT_WIDTH-1:0] shift,
    input logic                   relu
  );
    logic signed [ACC_WIDTH:0] v;
    logic        [OW-1:0]      r;
    v = {acc[ACC_WIDTH-1], acc};
    if (shift != '0) begin
      v = v + ((ACC_WIDTH+1)'(1) << (shift - 1'b1));
    end
    v = v >>> shift;
    // In range when all bits above the output sign bit match it.
    if (v[ACC_WIDTH:OW-1] == {(ACC_WIDTH-OW+2){v[ACC_WIDTH]}}) begin
      r = v[OW-1:0];
    end else if (v[ACC_WIDTH]) begin
      r = {1'b1, {(OW-1){1'b0}}};
    end else begin
      r = {1'b0, {(OW-1){1'b1}}};
    end
    if (relu && r[OW-1]) begin
      r = '0;
    end
    return r;
  endfunction

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int k = 0; k < K; k++) begin
      tap_f[k] = feature_in[k*FEATURE_WIDTH +: FEATURE_WIDTH];
      tap_w[k] = weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // NOTE: product and init registers carry no reset; they are only consumed behind a valid tag that is reset.
  always_ff @(posedge clk) begin
    if (en && in_accept) begin
      for (int k = 0; k < K; k++) begin
        if (k == 0 || !cfg_k1) begin
          prod_q[k] <= tap_f[k] * tap_w[k];
        end else begin
          prod_q[k] <= '0;
        end
      end
      if (in_first) begin
        init_q <= init_value;
      end
    end
  end

  // Adder tree over K sign-extended products; the sum wraps mod 2^ACC_WIDTH.
  always_comb begin
    dot = '0;
    for (int k = 0; k < K; k++) begin
      dot = dot + {{(ACC_WIDTH-PW){prod_q[k][PW-1]}}, prod_q[k]};
    end
    acc_d = s1_tag.first ? (init_q + dot) : (acc_q + dot);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      feature_out <= '0;
    end else if (en && s1_tag.valid) begin
      acc_q <= acc_d;
      if (s1_tag.last) begin
        feature_out <= post_process(acc_d, s1_tag.cfg.shift, s1_tag.cfg.relu);
      end
    end
  end

endmodule

// File: rtl/pe_array_acc.sv
// Second-generation PE array: PE_CORE_NUM lanes, each a K-tap signed dot
// product accumulated over a multi-beat frame, with bias/residual init and
// rounding shift, saturation and ReLU on the result.
// Ports:
//  DSP_clk, rst          clock, synchronous active-high reset
//  in_valid/in_ready     input beat handshake
//  in_first/in_last      frame delimiters
//  feature_in            K taps shared by all lanes, tap0 in LSBs
//  weight                lane-major, tap-minor weights
//  bias, adder_feature   per-lane init sources (sampled on first beat)
//  init_sel              0 = bias, 1 = adder_feature
//  cfg_k1                1x1 mode, per beat
//  cfg_shift, cfg_relu   output post-processing, sampled on first beat
//  out_valid/out_ready   result handshake
//  feature_out           lane i at [i*MAC_OUTPUT_WIDTH +: MAC_OUTPUT_WIDTH]
//  err_proto             sticky protocol error
module pe_array_acc
  import pe_array_acc_pkg::*;
(
  input  logic                                                  DSP_clk,
  input  logic                                                  rst,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic                                                  in_first,
  input  logic                                                  in_last,
  input  logic [FEATURE_WIDTH*PE_NUM_PRE_CORE-1:0]              feature_in,
  input  logic [WEIGHT_WIDTH*PE_NUM_PRE_CORE*PE_CORE_NUM-1:0]   weight,
  input  logic [ACC_WIDTH*PE_CORE_NUM-1:0]                      bias,
  input  logic [MAC_OUTPUT_WIDTH*PE_CORE_NUM-1:0]               adder_feature,
  input  logic                                                  init_sel,
  input  logic                                                  cfg_k1,
  input  logic [SHIFT_WIDTH-1:0]                                cfg_shift,
  input  logic                                                  cfg_relu,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [MAC_OUTPUT_WIDTH*PE_CORE_NUM-1:0]               feature_out,
  output logic                                                  err_proto
);

  localparam int K  = PE_NUM_PRE_CORE;
  localparam int OW = MAC_OUTPUT_WIDTH;
  localparam int WL = WEIGHT_WIDTH * K;

  frame_state_e state_q, state_d;
  logic         en;
  logic         accept;
  logic         beat_first;
  logic         proto_err;
  frame_cfg_t   frame_cfg_q;
  frame_cfg_t   beat_cfg;
  beat_tag_t    s1_tag_q;

  // A pending result that is not being drained freezes the whole pipeline.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Frame FSM: state register.
  always_ff @(posedge DSP_clk) begin
    if (rst) begin
      state_q <= ST_CLOSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM: next state. Any accepted non-last beat leaves a frame open,
  // including a misplaced first (restart) or a beat arriving while closed.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_last ? ST_CLOSED : ST_OPEN;
    end
  end

  // Frame FSM: outputs. A beat arriving with no open frame is treated as a
  // first beat so the lane loads its init value instead of stale state.
  always_comb begin
    beat_first = in_first || (state_q == ST_CLOSED);
    proto_err  = accept && (in_first ? (state_q == ST_OPEN) : (state_q == ST_CLOSED));
  end

  // Config is frozen at the frame's first beat and carried with every beat,
  // so a new frame entering stage 1 cannot disturb the one finishing.
  assign beat_cfg = beat_first ? '{shift: cfg_shift, relu: cfg_relu} : frame_cfg_q;

  always_ff @(posedge DSP_clk) begin
    if (rst) begin
      s1_tag_q    <= '0;
      frame_cfg_q <= '0;
      out_valid   <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      if (accept && beat_first) begin
        frame_cfg_q <= beat_cfg;
      end
      if (proto_err) begin
        err_proto <= 1'b1;
      end
      if (en) begin
        s1_tag_q  <= '{valid: accept, first: beat_first, last: in_last, cfg: beat_cfg};
        out_valid <= s1_tag_q.valid && s1_tag_q.last;
      end
    end
  end

  for (genvar g = 0; g < PE_CORE_NUM; g++) begin : g_lane
    logic [OW-1:0]        residual;
    logic [ACC_WIDTH-1:0] init_value;

    assign residual   = adder_feature[g*OW +: OW];
    assign init_value = init_sel ? {{(ACC_WIDTH-OW){residual[OW-1]}}, residual}
                                 : bias[g*ACC_WIDTH +: ACC_WIDTH];

    pe_lane u_lane (
      .clk         (DSP_clk),
      .rst         (rst),
      .en          (en),
      .in_accept   (accept),
      .in_first    (beat_first),
      .cfg_k1      (cfg_k1),
      .feature_in  (feature_in),
      .weight      (weight[g*WL +: WL]),
      .init_value  (init_value),
      .s1_tag      (s1_tag_q),
      .feature_out (feature_out[g*OW +: OW])
    );
  end

endmodule

// File: tb/tb_pe_array_acc.sv
// Randomized + directed bench for pe_array_acc against a frame-level
// arithmetic reference model with an expected-result queue.
module tb_pe_array_acc;
  import pe_array_acc_pkg::*;

  localparam int K  = PE_NUM_PRE_CORE;
  localparam int L  = PE_CORE_NUM;
  localparam int FW = FEATURE_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int OW = MAC_OUTPUT_WIDTH;

  typedef logic [L*OW-1:0] vec_t;

  logic                  DSP_clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready, in_first, in_last;
  logic [FW*K-1:0]       feature_in;
  logic [WW*K*L-1:0]     weight;
  logic [AW*L-1:0]       bias;
  logic [OW*L-1:0]       adder_feature;
  logic                  init_sel, cfg_k1, cfg_relu;
  logic [SHIFT_WIDTH-1:0] cfg_shift;
  logic                  out_valid, out_ready, err_proto;
  logic [OW*L-1:0]       feature_out;

  always #5 DSP_clk = ~DSP_clk;

  pe_array_acc dut (
    .DSP_clk       (DSP_clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_first      (in_first),
    .in_last       (in_last),
    .feature_in    (feature_in),
    .weight        (weight),
    .bias          (bias),
    .adder_feature (adder_feature),
    .init_sel      (init_sel),
    .cfg_k1        (cfg_k1),
    .cfg_shift     (cfg_shift),
    .cfg_relu      (cfg_relu),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .feature_out   (feature_out),
    .err_proto     (err_proto)
  );

  // Stimulus values for the next beat.
  int     f [K];
  int     w [L][K];
  longint b [L];
  int     a [L];

  // Reference model state.
  longint m_acc [L];
  bit     m_open;
  int     m_shift;
  bit     m_relu;
  bit     m_err;
  vec_t   exp_q [$];

  int  total, bad, n_out;
  bit  rnd_phase;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    logic [63:0] u;
    u = v;
    return longint'({{(64-AW){u[AW-1]}}, u[AW-1:0]});
  endfunction

  function automatic longint post(input longint acc, input int shift, input bit relu);
    longint v, maxv, minv;
    maxv = (longint'(1) <<< (OW-1)) - 1;
    minv = -(longint'(1) <<< (OW-1));
    v = acc;
    if (shift > 0) v = v + (longint'(1) <<< (shift-1));
    v = v >>> shift;
    if (v > maxv) v = maxv;
    if (v < minv) v = minv;
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  function automatic longint lane_out(input int l);
    logic [OW-1:0] v;
    v = feature_out[l*OW +: OW];
    return longint'($signed(v));
  endfunction

  function automatic int rand16();
    logic [15:0] r;
    r = 16'($urandom());
    return int'($signed(r));
  endfunction

  task automatic randomize_data();
    logic [AW-1:0] r48;
    for (int k = 0; k < K; k++) f[k] = rand16();
    for (int l = 0; l < L; l++) begin
      for (int k = 0; k < K; k++) w[l][k] = rand16();
      r48 = AW'({$urandom(), $urandom()});
      b[l] = ($urandom_range(0, 3) == 0) ? longint'($signed(r48)) : longint'(rand16()) * 1000;
      a[l] = int'($urandom());
    end
  endtask

  task automatic set_uniform(input int fv, input int wv, input longint bv);
    for (int k = 0; k < K; k++) f[k] = fv;
    for (int l = 0; l < L; l++) begin
      for (int k = 0; k < K; k++) w[l][k] = wv;
      b[l] = bv;
      a[l] = 0;
    end
  endtask

  task automatic pack();
    logic [63:0] t;
    for (int k = 0; k < K; k++) feature_in[k*FW +: FW] = FW'(f[k]);
    for (int l = 0; l < L; l++) begin
      for (int k = 0; k < K; k++) weight[(l*K+k)*WW +: WW] = WW'(w[l][k]);
      t = b[l];
      bias[l*AW +: AW] = t[AW-1:0];
      adder_feature[l*OW +: OW] = OW'(a[l]);
    end
  endtask

  // Frame-level rules: a beat starts a frame if flagged first or if no
  // frame is open; config latches at frame start; result on last.
  task automatic model_beat(input bit first, last, k1, isel, input int shift, input bit relu);
    bit     ef;
    longint dot, init;
    vec_t   v;
    ef = first || !m_open;
    if (first == m_open) m_err = 1'b1;
    if (ef) begin
      m_shift = shift;
      m_relu  = relu;
    end
    for (int l = 0; l < L; l++) begin
      dot = 0;
      for (int k = 0; k < K; k++)
        if (!(k1 && k > 0)) dot += longint'(f[k]) * longint'(w[l][k]);
      init = isel ? longint'(a[l]) : b[l];
      m_acc[l] = wrap_acc((ef ? init : m_acc[l]) + dot);
    end
    if (last) begin
      for (int l = 0; l < L; l++) v[l*OW +: OW] = OW'(post(m_acc[l], m_shift, m_relu));
      exp_q.push_back(v);
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  // Present one beat; returns at posedge+1 after it is accepted.
  task automatic beat(input bit first, last, k1, isel, input int shift, input bit relu);
    int n;
    bit ok;
    pack();
    in_first = first;  in_last  = last;   cfg_k1   = k1;
    init_sel = isel;   cfg_shift = SHIFT_WIDTH'(shift); cfg_relu = relu;
    in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge DSP_clk);
      ok = in_ready;
      n++;
    end
    if (ok) model_beat(first, last, k1, isel, shift, relu);
    else    check("accept_timeout", 0, 1);
    @(posedge DSP_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sync();
    @(posedge DSP_clk);
    #1;
  endtask

  // Returns at the negedge where out_valid is seen high.
  task automatic wait_out(input string tag);
    int n;
    n = 0;
    @(negedge DSP_clk);
    while (!out_valid && n < 50) begin
      @(negedge DSP_clk);
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge DSP_clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    sync();
  endtask

  // Scoreboard: every output transfer must match the oldest expected result.
  initial begin
    vec_t e;
    logic [OW-1:0] ev;
    forever begin
      @(negedge DSP_clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int l = 0; l < L; l++) begin
            ev = e[l*OW +: OW];
            check($sformatf("out_lane%0d", l), lane_out(l), longint'($signed(ev)));
          end
        end
        n_out++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge DSP_clk);
      #1;
      if (rnd_phase) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t snap;
    int   n, len;
    bit   fst;
    total = 0; bad = 0; n_out = 0; rnd_phase = 1'b0;
    m_open = 1'b0; m_err = 1'b0; m_shift = 0; m_relu = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    init_sel = 1'b0; cfg_k1 = 1'b0; cfg_shift = '0; cfg_relu = 1'b0;
    out_ready = 1'b1;
    set_uniform(0, 0, 0);
    pack();
    repeat (3) @(posedge DSP_clk);
    @(negedge DSP_clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_feature_out", (feature_out == '0), 1);
    check("rst_err", err_proto, 0);
    check("rst_in_ready", in_ready, 1);
    sync();
    rst = 1'b0;
    sync();

    // 1: single-beat frame, latency 2 edges.
    randomize_data();
    f[0] = 1; f[1] = 2; f[2] = 3;
    w[0][0] = 4; w[0][1] = 5; w[0][2] = 6;
    b[0] = 10;
    beat(1, 1, 0, 0, 0, 0);
    @(negedge DSP_clk);
    check("t1_lat_edge1", out_valid, 0);
    @(negedge DSP_clk);
    check("t1_lat_edge2", out_valid, 1);
    check("t1_lane0", lane_out(0), 42);
    sync();

    // 2: four-beat frame, no intermediate result.
    set_uniform(1, 2, 0);
    beat(1, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 0, 0, 0);
    beat(0, 1, 0, 0, 0, 0);
    @(negedge DSP_clk);
    check("t2_no_early", out_valid, 0);
    wait_out("t2_out");
    check("t2_lane0", lane_out(0), 24);
    check("t2_lane15", lane_out(L-1), 24);
    sync();

    // 3: residual init, ReLU on/off.
    set_uniform(0, 0, 0);
    f[0] = 1; f[1] = 2; f[2] = 3;
    for (int k = 0; k < K; k++) w[5][k] = 5;
    a[5] = -100;
    beat(1, 1, 0, 1, 0, 1);
    wait_out("t3a_out");
    check("t3_relu_lane5", lane_out(5), 0);
    sync();
    beat(1, 1, 0, 1, 0, 0);
    wait_out("t3b_out");
    check("t3_norelu_lane5", lane_out(5), -70);
    sync();

    // 4: rounding shift and saturation.
    set_uniform(0, 0, 0);
    b[0] = 'h18; b[1] = 'h17; b[2] = longint'(1) <<< 40; b[3] = -(longint'(1) <<< 40);
    beat(1, 1, 0, 0, 4, 0);
    wait_out("t4_out");
    check("t4_round_up", lane_out(0), 2);
    check("t4_round_down", lane_out(1), 1);
    check("t4_sat_max", lane_out(2), 64'h7FFF_FFFF);
    check("t4_sat_min", lane_out(3), -(longint'(1) <<< 31));
    sync();

    // 5a: back-to-back single-beat frames give one result per cycle.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          randomize_data();
          beat(1, 1, 0, i[0], i % 6, i[1]);
        end
      end
      begin
        n = 0;
        @(negedge DSP_clk);
        while (!out_valid && n < 20) begin
          @(negedge DSP_clk);
          n++;
        end
        for (int i = 0; i < 7; i++) begin
          @(negedge DSP_clk);
          check("t5_full_rate", out_valid, 1);
        end
      end
    join
    wait_idle();

    // 5b: consumer stall while frames stream.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          randomize_data();
          beat(1, 1, 0, 0, 3, 0);
        end
      end
      begin
        repeat (3) @(posedge DSP_clk);
        #1;
        out_ready = 1'b0;
        @(negedge DSP_clk);
        snap = feature_out;
        check("t5_stall_valid", out_valid, 1);
        check("t5_stall_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
          @(negedge DSP_clk);
          check("t5_stall_ready", in_ready, 0);
          check("t5_stall_stable", (feature_out == snap), 1);
        end
        @(posedge DSP_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // 6a: first while open restarts the frame and flags an error.
    randomize_data();
    beat(1, 0, 0, 0, 0, 0);
    set_uniform(1, 1, 0);
    beat(1, 1, 0, 0, 0, 0);
    wait_out("t6a_out");
    check("t6a_restart_lane0", lane_out(0), 3);
    check("t6a_err", err_proto, 1);
    sync();
    wait_idle();

    // 6b: reset mid-frame discards partial sum, pending output and error.
    randomize_data();
    beat(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    m_open = 1'b0;
    m_err  = 1'b0;
    @(negedge DSP_clk);
    check("t6b_rst_valid", out_valid, 0);
    check("t6b_rst_err", err_proto, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge DSP_clk);
      check("t6b_no_output", out_valid, 0);
    end
    sync();

    // 6c: 1x1 mode uses tap0 only.
    set_uniform(0, 0, 0);
    f[0] = 7; f[1] = 9; f[2] = 9;
    w[0][0] = 3; w[0][1] = 9; w[0][2] = 9;
    beat(1, 1, 1, 0, 0, 0);
    wait_out("t6c_out");
    check("t6c_k1_lane0", lane_out(0), 21);
    check("t6c_err_clear", err_proto, 0);
    sync();

    // 6d: non-first beat with no open frame loads init and flags an error.
    set_uniform(0, 0, 0);
    f[0] = 2;
    w[0][0] = 5;
    b[0] = 100;
    beat(0, 1, 0, 0, 0, 0);
    wait_out("t6d_out");
    check("t6d_lane0", lane_out(0), 110);
    check("t6d_err", err_proto, 1);
    sync();
    wait_idle();

    // Random frames with bubbles, back-pressure and occasional bad framing.
    rnd_phase = 1'b1;
    for (int fr = 0; fr < 150; fr++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        randomize_data();
        fst = (i == 0) ^ ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 3) == 0) sync();
        beat(fst, (i == len - 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
             $urandom_range(0, 20), $urandom_range(0, 1));
      end
    end
    rnd_phase = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("rand_err_flag", err_proto, m_err);
    check("rand_results_seen", (n_out > 150), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
